restoring_divider_16_8: RTL

//   Sequential unsigned restoring divider: the inverse datapath of the 8-bit Vedic

---
 rtl/restoring_divider_16_8.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/restoring_divider_16_8.sv
// Purpose : sequential unsigned restoring divider, 16-bit dividend / 8-bit divisor -> 16-bit quotient, 8-bit remainder.
// Latency : one quotient bit per clock; done is seen 17 edges after accept (1 edge for divide-by-zero).
// Backpr. : start is taken only while busy=0 (IDLE or DONE); start during RUN is dropped, not queued.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; abandons any division in flight
//   start        request, sampled only when busy=0
//   dividend     unsigned dividend, latched on the accept edge
//   divisor      unsigned divisor, latched on the accept edge
//   busy         high while iterating (RUN)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient, held until the next accept
//   remainder    registered remainder, held until the next accept
//   div_by_zero  set with done when the latched divisor was zero
module restoring_divider_16_8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after the last iteration this register holds the full quotient.
    logic [DIVIDEND_W-1:0] shift_q, shift_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    // Partial remainder is always < divisor between iterations, so it fits
    // in DIVISOR_W bits; only the trial value needs the extra bit.
    logic [DIVISOR_W-1:0]  part_q, part_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // One restoring step
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff;
    logic                  q_bit;
    logic [DIVISOR_W-1:0]  part_next;
    logic [DIVIDEND_W-1:0] shift_next;
    logic                  accept;

    always_comb begin
        trial = {part_q, shift_q[DIVIDEND_W-1]};
        q_bit = (trial >= {1'b0, dvs_q});
        // When q_bit=1 the true difference is < divisor, so the low
        // DIVISOR_W bits of the subtraction are exact.
        diff       = trial[DIVISOR_W-1:0] - dvs_q;
        // When q_bit=0 the trial is < divisor, so its top bit is zero.
        part_next  = q_bit ? diff : trial[DIVISOR_W-1:0];
        shift_next = {shift_q[DIVIDEND_W-2:0], q_bit};
    end

    // busy_q is the registered image of state==RUN
    assign accept = start && !busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        dvs_d       = dvs_q;
        part_d      = part_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_RUN: begin
                cnt_d   = cnt_q + 1'b1;
                shift_d = shift_next;
                part_d  = part_next;
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = shift_next;
                    remainder_d = part_next;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept is possible from IDLE and from DONE, which allows
        // back-to-back divisions without a dead cycle.
        if (accept) begin
            shift_d = dividend;
            dvs_d   = divisor;
            part_d  = '0;
            cnt_d   = '0;
            if (divisor == '0) begin
                // Short-circuit: no iterations, saturated quotient.
                state_d     = ST_DONE;
                quotient_d  = '1;
                remainder_d = '0;
                dbz_d       = 1'b1;
            end else begin
                state_d = ST_RUN;
                dbz_d   = 1'b0;
            end
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            dvs_q       <= dvs_d;
            part_q      <= part_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
